// File: rtl/wb_pkg.sv
// wb_pkg: load-kind encoding, FSM states and default widths for the writeback stage
package wb_pkg;
  localparam int XLEN_W = 32;
  localparam int RAW_W = 5;
  localparam int CP0AW_W = 8;
  localparam int LS_W = 3;
  localparam logic [LS_W-1:0] LS_NONE = 3'd0;
  localparam logic [LS_W-1:0] LS_LW = 3'd1;
  localparam logic [LS_W-1:0] LS_LH = 3'd2;
  localparam logic [LS_W-1:0] LS_LHU = 3'd3;
  localparam logic [LS_W-1:0] LS_LB = 3'd4;
  localparam logic [LS_W-1:0] LS_LBU = 3'd5;
  typedef enum logic [1:0] {S_IDLE, S_WAIT_MEM, S_COMMIT} state_e;
endpackage

// File: rtl/wb_load_align.sv
// wb_load_align: selects and extends the byte/halfword addressed by off from a raw load word
module wb_load_align
  import wb_pkg::*;
#(
  parameter int XLEN = XLEN_W
) (
  input  logic [XLEN-1:0] raw,
  input  logic [LS_W-1:0] kind,
  input  logic [1:0]      off,
  output logic [XLEN-1:0] res
);
  logic [15:0] h;
  logic [7:0] b;
  assign h = off[1] ? raw[31:16] : raw[15:0];
  assign b = raw[{off, 3'b000} +: 8];
  always_comb begin
    res = kind == LS_LW  ? raw :
          kind == LS_LH  ? {{(XLEN-16){h[15]}}, h} :
          kind == LS_LHU ? {{(XLEN-16){1'b0}}, h} :
          kind == LS_LB  ? {{(XLEN-8){b[7]}}, b} :
          kind == LS_LBU ? {{(XLEN-8){1'b0}}, b} : raw;
  end
endmodule

// File: rtl/wb_stage_multi.sv
// wb_stage_multi: multi-lane writeback stage; waits for load data, aligns it and commits all lanes in one cycle
module wb_stage_multi
  import wb_pkg::*;
#(
  parameter int LANES = 2,
  parameter int XLEN = XLEN_W,
  parameter int RAW = RAW_W,
  parameter int CP0AW = CP0AW_W
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES-1:0]        in_rf_we,
  input  logic [LANES*RAW-1:0]    in_rf_waddr,
  input  logic [LANES*XLEN-1:0]   in_alu,
  input  logic [LANES*LS_W-1:0]   in_ls_kind,
  input  logic [LANES*2-1:0]      in_byte_off,
  input  logic [1:0]              in_hilo_we,
  input  logic [63:0]             in_hilo_wdata,
  input  logic                    in_cp0_we,
  input  logic [CP0AW-1:0]        in_cp0_waddr,
  input  logic [XLEN-1:0]         in_cp0_wdata,
  input  logic [LANES-1:0]        mem_data_ok,
  input  logic [LANES*XLEN-1:0]   mem_rdata,
  output logic [LANES-1:0]        rf_we,
  output logic [LANES*RAW-1:0]    rf_waddr,
  output logic [LANES*XLEN-1:0]   rf_wdata,
  output logic [1:0]              hilo_we,
  output logic [63:0]             hilo_wdata,
  output logic                    cp0_we,
  output logic [CP0AW-1:0]        cp0_waddr,
  output logic [XLEN-1:0]         cp0_wdata,
  output logic                    wb_busy
);
  state_e state_q, state_d;
  logic [LANES-1:0] we_q, we_d, pend_q, pend_d, pend_acc;
  logic [LANES*RAW-1:0] waddr_q, waddr_d;
  logic [LANES*XLEN-1:0] alu_q, alu_d, rdata_q, rdata_d;
  logic [LANES*LS_W-1:0] kind_q, kind_d;
  logic [LANES*2-1:0] off_q, off_d;
  logic [1:0] hilo_we_q, hilo_we_d;
  logic [63:0] hilo_wdata_q, hilo_wdata_d;
  logic cp0_we_q, cp0_we_d;
  logic [CP0AW-1:0] cp0_waddr_q, cp0_waddr_d;
  logic [XLEN-1:0] cp0_wdata_q, cp0_wdata_d;
  logic [XLEN-1:0] aligned [LANES];
  logic accept, commit;
  assign in_ready = state_q == S_IDLE || state_q == S_COMMIT;
  assign wb_busy = state_q == S_WAIT_MEM;
  assign accept = in_valid && in_ready;
  assign commit = state_q == S_COMMIT;
  for (genvar g = 0; g < LANES; g++) begin : g_align
    wb_load_align #(.XLEN(XLEN)) u_align (
      .raw (rdata_q[g*XLEN +: XLEN]),
      .kind(kind_q[g*LS_W +: LS_W]),
      .off (off_q[g*2 +: 2]),
      .res (aligned[g])
    );
  end
  always_comb begin
    state_d = state_q;
    we_d = we_q;
    waddr_d = waddr_q;
    alu_d = alu_q;
    kind_d = kind_q;
    off_d = off_q;
    rdata_d = rdata_q;
    pend_d = pend_q;
    hilo_we_d = hilo_we_q;
    hilo_wdata_d = hilo_wdata_q;
    cp0_we_d = cp0_we_q;
    cp0_waddr_d = cp0_waddr_q;
    cp0_wdata_d = cp0_wdata_q;
    pend_acc = '0;
    for (int i = 0; i < LANES; i++) pend_acc[i] = in_ls_kind[i*LS_W +: LS_W] != LS_NONE;
    if (accept) begin
      we_d = in_rf_we;
      waddr_d = in_rf_waddr;
      alu_d = in_alu;
      kind_d = in_ls_kind;
      off_d = in_byte_off;
      pend_d = pend_acc;
      hilo_we_d = in_hilo_we;
      hilo_wdata_d = in_hilo_wdata;
      cp0_we_d = in_cp0_we;
      cp0_waddr_d = in_cp0_waddr;
      cp0_wdata_d = in_cp0_wdata;
      state_d = |pend_acc ? S_WAIT_MEM : S_COMMIT;
    end else if (state_q == S_WAIT_MEM) begin
      for (int i = 0; i < LANES; i++) begin
        if (mem_data_ok[i] && pend_q[i]) begin
          rdata_d[i*XLEN +: XLEN] = mem_rdata[i*XLEN +: XLEN];
          pend_d[i] = 1'b0;
        end
      end
      state_d = |pend_d ? S_WAIT_MEM : S_COMMIT;
    end else if (commit) begin
      state_d = S_IDLE;
    end
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      we_q <= '0;
      waddr_q <= '0;
      alu_q <= '0;
      kind_q <= '0;
      off_q <= '0;
      rdata_q <= '0;
      pend_q <= '0;
      hilo_we_q <= '0;
      hilo_wdata_q <= '0;
      cp0_we_q <= 1'b0;
      cp0_waddr_q <= '0;
      cp0_wdata_q <= '0;
    end else begin
      state_q <= state_d;
      we_q <= we_d;
      waddr_q <= waddr_d;
      alu_q <= alu_d;
      kind_q <= kind_d;
      off_q <= off_d;
      rdata_q <= rdata_d;
      pend_q <= pend_d;
      hilo_we_q <= hilo_we_d;
      hilo_wdata_q <= hilo_wdata_d;
      cp0_we_q <= cp0_we_d;
      cp0_waddr_q <= cp0_waddr_d;
      cp0_wdata_q <= cp0_wdata_d;
    end
  end
  always_comb begin
    rf_we = '0;
    rf_waddr = commit ? waddr_q : '0;
    rf_wdata = '0;
    hilo_we = commit ? hilo_we_q : '0;
    hilo_wdata = commit ? hilo_wdata_q : '0;
    cp0_we = commit && cp0_we_q;
    cp0_waddr = commit ? cp0_waddr_q : '0;
    cp0_wdata = commit ? cp0_wdata_q : '0;
    for (int i = 0; i < LANES; i++) begin
      rf_wdata[i*XLEN +: XLEN] = !commit ? '0 :
          kind_q[i*LS_W +: LS_W] == LS_NONE ? alu_q[i*XLEN +: XLEN] : aligned[i];
      rf_we[i] = commit && we_q[i] && waddr_q[i*RAW +: RAW] != '0;
      for (int j = i + 1; j < LANES; j++)
        if (we_q[j] && waddr_q[j*RAW +: RAW] == waddr_q[i*RAW +: RAW]) rf_we[i] = 1'b0;
    end
  end
endmodule

// File: tb/tb_wb_stage_multi.sv
// tb_wb_stage_multi: table vectors, hand sequences and randomized bundles checked against a reference model
module tb_wb_stage_multi;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [1:0] in_rf_we = '0;
  logic [9:0] in_rf_waddr = '0;
  logic [63:0] in_alu = '0;
  logic [5:0] in_ls_kind = '0;
  logic [3:0] in_byte_off = '0;
  logic [1:0] in_hilo_we = '0;
  logic [63:0] in_hilo_wdata = '0;
  logic in_cp0_we = 1'b0;
  logic [7:0] in_cp0_waddr = '0;
  logic [31:0] in_cp0_wdata = '0;
  logic [1:0] mem_data_ok = '0;
  logic [63:0] mem_rdata = '0;
  logic [1:0] rf_we;
  logic [9:0] rf_waddr;
  logic [63:0] rf_wdata;
  logic [1:0] hilo_we;
  logic [63:0] hilo_wdata;
  logic cp0_we;
  logic [7:0] cp0_waddr;
  logic [31:0] cp0_wdata;
  logic wb_busy;
  int checks = 0;
  int errors = 0;
  wb_stage_multi dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr), .in_alu(in_alu),
    .in_ls_kind(in_ls_kind), .in_byte_off(in_byte_off),
    .in_hilo_we(in_hilo_we), .in_hilo_wdata(in_hilo_wdata),
    .in_cp0_we(in_cp0_we), .in_cp0_waddr(in_cp0_waddr), .in_cp0_wdata(in_cp0_wdata),
    .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .hilo_we(hilo_we), .hilo_wdata(hilo_wdata),
    .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
    .wb_busy(wb_busy)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [1:0] we;
    logic [9:0] addr;
    logic [63:0] alu;
    logic [5:0] kind;
    logic [3:0] off;
    logic [63:0] rdata;
  } bundle_t;
  typedef struct {
    bundle_t b;
    int d0;
    int d1;
    logic [1:0] ewe;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;
  function automatic bundle_t mk(input logic [1:0] we, input logic [4:0] a0, input logic [4:0] a1,
      input logic [31:0] alu0, input logic [31:0] alu1, input logic [2:0] k0, input logic [2:0] k1,
      input logic [1:0] o0, input logic [1:0] o1, input logic [31:0] r0, input logic [31:0] r1);
    bundle_t b;
    b.we = we;
    b.addr = {a1, a0};
    b.alu = {alu1, alu0};
    b.kind = {k1, k0};
    b.off = {o1, o0};
    b.rdata = {r1, r0};
    return b;
  endfunction
  function automatic logic [31:0] ref_data(input logic [2:0] k, input logic [1:0] off,
      input logic [31:0] alu, input logic [31:0] raw);
    logic [31:0] by, hw;
    by = (raw >> (8 * off)) & 32'hFF;
    hw = (raw >> (16 * (off / 2))) & 32'hFFFF;
    case (k)
      3'd0: return alu;
      3'd2: return hw >= 32'h8000 ? hw + 32'hFFFF_0000 : hw;
      3'd3: return hw;
      3'd4: return by >= 32'h80 ? by + 32'hFFFF_FF00 : by;
      3'd5: return by;
      default: return raw;
    endcase
  endfunction
  function automatic logic [1:0] ref_we(input bundle_t b);
    logic [1:0] w;
    w[1] = b.we[1] && b.addr[9:5] != 0;
    w[0] = b.we[0] && b.addr[4:0] != 0 && !(b.we[1] && b.addr[9:5] == b.addr[4:0]);
    return w;
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input bundle_t b);
    in_rf_we = b.we;
    in_rf_waddr = b.addr;
    in_alu = b.alu;
    in_ls_kind = b.kind;
    in_byte_off = b.off;
    in_hilo_we = '0;
    in_hilo_wdata = '0;
    in_cp0_we = 1'b0;
    in_cp0_waddr = '0;
    in_cp0_wdata = '0;
  endtask
  task automatic run(input bundle_t b, input int d0, input int d1, input logic [1:0] ewe,
      input logic [31:0] e0, input logic [31:0] e1);
    logic [1:0] pend;
    int dl [2];
    int dmax;
    pend[0] = b.kind[2:0] != 0;
    pend[1] = b.kind[5:3] != 0;
    dl[0] = d0;
    dl[1] = d1;
    dmax = 0;
    for (int i = 0; i < 2; i++) if (pend[i] && dl[i] > dmax) dmax = dl[i];
    @(posedge clk);
    #1;
    drive(b);
    in_valid = 1'b1;
    mem_data_ok = 2'($urandom);
    mem_rdata = {$urandom, $urandom};
    @(negedge clk);
    check("in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int c = 1; c <= dmax; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (pend[i] && dl[i] == c) begin
          mem_data_ok[i] = 1'b1;
          mem_rdata[i*32 +: 32] = b.rdata[i*32 +: 32];
        end else begin
          mem_data_ok[i] = (!pend[i] || c > dl[i]) ? 1'($urandom) : 1'b0;
          mem_rdata[i*32 +: 32] = $urandom;
        end
      end
      @(negedge clk);
      check("wait_busy", 64'(wb_busy), 64'd1);
      check("wait_no_commit", 64'(rf_we), 64'd0);
      @(posedge clk);
      #1;
    end
    mem_data_ok = '0;
    @(negedge clk);
    check("commit_we", 64'(rf_we), 64'(ewe));
    if (ewe[0]) begin
      check("wdata0", 64'(rf_wdata[31:0]), 64'(e0));
      check("waddr0", 64'(rf_waddr[4:0]), 64'(b.addr[4:0]));
    end
    if (ewe[1]) begin
      check("wdata1", 64'(rf_wdata[63:32]), 64'(e1));
      check("waddr1", 64'(rf_waddr[9:5]), 64'(b.addr[9:5]));
    end
    check("commit_busy", 64'(wb_busy), 64'd0);
    check("commit_hilo", 64'({hilo_we, cp0_we}), 64'd0);
    @(negedge clk);
    check("one_shot_we", 64'(rf_we), 64'd0);
    check("idle_ready", 64'(in_ready), 64'd1);
  endtask
  vec_t tbl [10];
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    bundle_t b;
    tbl[0] = '{mk(2'b11, 5'd3, 5'd4, 32'h11, 32'h22, 3'd0, 3'd0, 2'd0, 2'd0, 32'h0, 32'h0), 1, 1, 2'b11, 32'h11, 32'h22};
    tbl[1] = '{mk(2'b11, 5'd1, 5'd7, 32'h9, 32'h77, 3'd4, 3'd0, 2'd3, 2'd0, 32'h80FF_1234, 32'h0), 2, 1, 2'b11, 32'hFFFF_FF80, 32'h77};
    tbl[2] = '{mk(2'b11, 5'd2, 5'd8, 32'h0, 32'h0, 3'd3, 3'd1, 2'd2, 2'd0, 32'h80FF_1234, 32'hDEAD_BEEF), 2, 1, 2'b11, 32'h0000_80FF, 32'hDEAD_BEEF};
    tbl[3] = '{mk(2'b11, 5'd5, 5'd5, 32'hA, 32'hB, 3'd0, 3'd0, 2'd0, 2'd0, 32'h0, 32'h0), 1, 1, 2'b10, 32'h0, 32'hB};
    tbl[4] = '{mk(2'b11, 5'd0, 5'd9, 32'h5, 32'h99, 3'd0, 3'd0, 2'd0, 2'd0, 32'h0, 32'h0), 1, 1, 2'b10, 32'h0, 32'h99};
    tbl[5] = '{mk(2'b11, 5'd9, 5'd0, 32'h5, 32'h99, 3'd0, 3'd0, 2'd0, 2'd0, 32'h0, 32'h0), 1, 1, 2'b01, 32'h5, 32'h0};
    tbl[6] = '{mk(2'b11, 5'd12, 5'd13, 32'h0, 32'h0, 3'd2, 3'd5, 2'd0, 2'd1, 32'h1234_8001, 32'h1234_80F0), 1, 1, 2'b11, 32'hFFFF_8001, 32'h0000_0080};
    tbl[7] = '{mk(2'b11, 5'd14, 5'd15, 32'h0, 32'h0, 3'd2, 3'd4, 2'd2, 2'd1, 32'h80FF_1234, 32'h0000_7F00), 3, 1, 2'b11, 32'hFFFF_80FF, 32'h0000_007F};
    tbl[8] = '{mk(2'b01, 5'd16, 5'd0, 32'h0, 32'h0, 3'd7, 3'd0, 2'd3, 2'd0, 32'hCAFE_F00D, 32'h0), 2, 1, 2'b01, 32'hCAFE_F00D, 32'h0};
    tbl[9] = '{mk(2'b11, 5'd6, 5'd6, 32'h0, 32'h66, 3'd1, 3'd0, 2'd0, 2'd0, 32'h1111_2222, 32'h0), 1, 1, 2'b10, 32'h0, 32'h66};
    #23;
    check("rst_ready", 64'(in_ready), 64'd1);
    check("rst_busy", 64'(wb_busy), 64'd0);
    check("rst_rf", {rf_we, rf_waddr, rf_wdata[51:0]}, 64'd0);
    check("rst_hilo", 64'({hilo_we, cp0_we, cp0_waddr}) | hilo_wdata | 64'(cp0_wdata), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    for (int n = 0; n < 10; n++) run(tbl[n].b, tbl[n].d0, tbl[n].d1, tbl[n].ewe, tbl[n].e0, tbl[n].e1);
    @(posedge clk);
    #1;
    drive(tbl[0].b);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    drive(mk(2'b11, 5'd10, 5'd11, 32'h100, 32'h200, 3'd0, 3'd0, 2'd0, 2'd0, 32'h0, 32'h0));
    @(negedge clk);
    check("b2b_first_we", 64'(rf_we), 64'd3);
    check("b2b_first_data", rf_wdata, 64'h0000_0022_0000_0011);
    check("b2b_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_second_we", 64'(rf_we), 64'd3);
    check("b2b_second_data", rf_wdata, 64'h0000_0200_0000_0100);
    @(negedge clk);
    check("b2b_one_shot", 64'(rf_we), 64'd0);
    @(posedge clk);
    #1;
    drive(mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 3'd0, 3'd0, 2'd0, 2'd0, 32'h0, 32'h0));
    in_hilo_we = 2'b11;
    in_hilo_wdata = 64'h1234_5678_9ABC_DEF0;
    in_cp0_we = 1'b1;
    in_cp0_waddr = 8'h60;
    in_cp0_wdata = 32'hA5A5_0001;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    drive(mk(2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 3'd0, 3'd0, 2'd0, 2'd0, 32'h0, 32'h0));
    @(negedge clk);
    check("hilo_we", 64'(hilo_we), 64'd3);
    check("hilo_wdata", hilo_wdata, 64'h1234_5678_9ABC_DEF0);
    check("cp0_we", 64'(cp0_we), 64'd1);
    check("cp0_waddr", 64'(cp0_waddr), 64'h60);
    check("cp0_wdata", 64'(cp0_wdata), 64'hA5A5_0001);
    @(negedge clk);
    check("hilo_cp0_one_shot", 64'({hilo_we, cp0_we}), 64'd0);
    @(posedge clk);
    #1;
    drive(mk(2'b01, 5'd20, 5'd0, 32'h0, 32'h0, 3'd1, 3'd0, 2'd0, 2'd0, 32'h0, 32'h0));
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("rstmid_busy", 64'(wb_busy), 64'd1);
    #1;
    resetn = 1'b0;
    #1;
    check("rstmid_async_ready", 64'(in_ready), 64'd1);
    check("rstmid_async_busy", 64'(wb_busy), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    mem_data_ok = 2'b01;
    mem_rdata = 64'h0000_0000_1357_9BDF;
    @(posedge clk);
    #1;
    mem_data_ok = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rstmid_no_commit", 64'({rf_we, wb_busy, in_ready}), 64'd1);
    end
    for (int n = 0; n < 60; n++) begin
      int r0, r1;
      r0 = int'($urandom_range(0, 11));
      r1 = int'($urandom_range(0, 11));
      b = mk(2'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), $urandom, $urandom,
             r0 > 7 ? 3'd0 : 3'(r0), r1 > 7 ? 3'd0 : 3'(r1), 2'($urandom), 2'($urandom), $urandom, $urandom);
      run(b, int'($urandom_range(1, 3)), int'($urandom_range(1, 3)), ref_we(b),
          ref_data(b.kind[2:0], b.off[1:0], b.alu[31:0], b.rdata[31:0]),
          ref_data(b.kind[5:3], b.off[3:2], b.alu[63:32], b.rdata[63:32]));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
